// File: rtl/memory_stream_source_pkg.sv
// Shared types for memory_stream_source: replay FSM states and output buffer sizing.
package memory_stream_source_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // Two slots cover the 1-cycle RAM read latency at full throughput.
  localparam int BUF_DEPTH = 2;

  // Buffer entry at the default stream width; the top builds the same layout at its DATA_W.
  localparam int BUF_DATA_W = 32;

  typedef struct packed {
    logic [BUF_DATA_W-1:0] data;
    logic                  last;
  } buf_entry_t;

endpackage

// File: rtl/memory_stream_source_ram.sv
// Simple dual-port synchronous RAM: one write port, one registered read port.
// A same-address read and write in one cycle returns the previous contents.
module source_ram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic              re,
  input  logic [ADDR_W-1:0] ra,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
    if (re) q <= mem[ra];
  end

endmodule

// File: rtl/memory_stream_source.sv
// Streaming memory source: replays a (base, length) RAM window on a valid/ready stream.
// Optional beat counter output enabled by defining MEMORY_STREAM_SOURCE_STATS_EN.
module memory_stream_source
  import memory_stream_source_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic              clk_hifreq,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              start,
  input  logic              stop,
  input  logic              loop,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  input  logic              ready,
  output logic              valid,
  output logic [DATA_W-1:0] data_out,
  output logic              last,
  output logic              busy,
  output logic              done
`ifdef MEMORY_STREAM_SOURCE_STATS_EN
  ,
  output logic [31:0]       beat_count
`endif
);

  // Handshake: a beat transfers on a rising edge where valid && ready; once valid
  // is high it stays high, with data_out/last unchanged, until that transfer.

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
  } entry_t;

  localparam logic [ADDR_W:0]   LEN_ONE = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] OFF_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_e            state, state_nxt;
  logic [ADDR_W-1:0] base_q, offset_q, offset_nxt;
  logic [ADDR_W:0]   len_q;
  logic              loop_q;
  logic              capture, done_nxt;

  logic              rd_pend, rd_pend_last;
  logic              issue, is_last_off;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] ram_q;

  entry_t            buf_mem [BUF_DEPTH];
  logic              wr_ptr, rd_ptr;
  logic [1:0]        occ, level;
  logic              push, pop;

  assign push = rd_pend;
  assign pop  = valid && ready;

  // Occupancy after this edge, counting the read landing now and the beat leaving now;
  // crediting the pop is what keeps ready-high streaming free of bubbles.
  assign level = occ + {1'b0, rd_pend} - {1'b0, pop};

  assign is_last_off = ({1'b0, offset_q} == (len_q - LEN_ONE));
  assign issue       = (state == RUN) && !stop && (level < 2'd2);
  assign rd_addr     = base_q + offset_q;

  always_comb begin
    state_nxt  = state;
    offset_nxt = offset_q;
    done_nxt   = 1'b0;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (start && (length != '0)) begin
          state_nxt  = RUN;
          capture    = 1'b1;
          offset_nxt = '0;
        end
      end
      RUN: begin
        if (stop) begin
          state_nxt = DRAIN;
        end else if (issue) begin
          if (is_last_off) begin
            offset_nxt = '0;
            if (!loop_q) state_nxt = DRAIN;
          end else begin
            offset_nxt = offset_q + OFF_ONE;
          end
        end
      end
      DRAIN: begin
        if (level == 2'd0) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_hifreq or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      offset_q     <= '0;
      base_q       <= '0;
      len_q        <= '0;
      loop_q       <= 1'b0;
      rd_pend      <= 1'b0;
      rd_pend_last <= 1'b0;
      done         <= 1'b0;
      wr_ptr       <= 1'b0;
      rd_ptr       <= 1'b0;
      occ          <= 2'd0;
      for (int i = 0; i < BUF_DEPTH; i++) buf_mem[i] <= '0;
    end else begin
      state        <= state_nxt;
      offset_q     <= offset_nxt;
      rd_pend      <= issue;
      rd_pend_last <= issue && is_last_off;
      done         <= done_nxt;
      if (capture) begin
        base_q <= base_addr;
        len_q  <= length;
        loop_q <= loop;
      end
      if (push) begin
        buf_mem[wr_ptr] <= '{data: ram_q, last: rd_pend_last};
        wr_ptr          <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      occ <= occ + {1'b0, push} - {1'b0, pop};
    end
  end

  assign valid    = (occ != 2'd0);
  assign data_out = buf_mem[rd_ptr].data;
  assign last     = valid && buf_mem[rd_ptr].last;
  assign busy     = (state != IDLE);

`ifdef MEMORY_STREAM_SOURCE_STATS_EN
  always_ff @(posedge clk_hifreq or negedge rst_n) begin
    if (!rst_n) begin
      beat_count <= '0;
    end else if (capture) begin
      beat_count <= '0;
    end else if (pop && (beat_count != 32'hFFFF_FFFF)) begin
      beat_count <= beat_count + 32'd1;
    end
  end
`endif

  source_ram #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk(clk_hifreq),
    .we (wr_en),
    .wa (wr_addr),
    .wd (wr_data),
    .re (issue),
    .ra (rd_addr),
    .q  (ram_q)
  );

endmodule

// File: tb/tb_memory_stream_source.sv
// Self-checking bench for memory_stream_source: table of replay windows plus corner sequences.
module tb_memory_stream_source;

  localparam int DW    = 32;
  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;

  // clock / reset
  logic clk_hifreq = 1'b0;
  logic rst_n;
  always #5 clk_hifreq = ~clk_hifreq;

  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          start, stop, loop;
  logic [AW-1:0] base_addr;
  logic [AW:0]   length;
  logic          ready;
  logic          valid;
  logic [DW-1:0] data_out;
  logic          last, busy, done;
`ifdef MEMORY_STREAM_SOURCE_STATS_EN
  logic [31:0]   beat_count;
`endif

  memory_stream_source #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk_hifreq(clk_hifreq),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .start     (start),
    .stop      (stop),
    .loop      (loop),
    .base_addr (base_addr),
    .length    (length),
    .ready     (ready),
    .valid     (valid),
    .data_out  (data_out),
    .last      (last),
    .busy      (busy),
    .done      (done)
`ifdef MEMORY_STREAM_SOURCE_STATS_EN
    ,
    .beat_count(beat_count)
`endif
  );

  // scoreboard / reference state
  logic [DW-1:0] mem_model [DEPTH];
  logic [DW:0]   exp_q [$];
  int            n_tests = 0;
  int            n_fail  = 0;

  logic          s_valid, s_beat, s_last, s_done, s_busy;
  logic [DW-1:0] s_data;
  logic          prev_valid = 1'b0, prev_ready = 1'b0, prev_last = 1'b0;
  logic [DW-1:0] prev_data = '0;

  typedef struct {
    int base;
    int len;
    bit lp;
    int pct;
    int beats;
    bit restart;
    bit both;
  } case_t;

  case_t cases [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One cycle: drive inputs after the falling edge, sample outputs 1 time unit later.
  task automatic tick(input bit rdy, input bit st, input bit sp);
    @(negedge clk_hifreq);
    ready = rdy;
    start = st;
    stop  = sp;
    #1;
    if (prev_valid && !prev_ready)
      check("stall_hold", {30'd0, valid, last, data_out}, {30'd0, 1'b1, prev_last, prev_data});
    s_valid = valid;
    s_beat  = valid && ready;
    s_data  = data_out;
    s_last  = last;
    s_done  = done;
    s_busy  = busy;
    prev_valid = valid;
    prev_ready = ready;
    prev_data  = data_out;
    prev_last  = last;
  endtask

  task automatic ram_write(input int addr, input logic [DW-1:0] d);
    @(negedge clk_hifreq);
    wr_en   = 1'b1;
    wr_addr = AW'(addr);
    wr_data = d;
    mem_model[addr] = d;
  endtask

  task automatic ram_write_end();
    @(negedge clk_hifreq);
    wr_en = 1'b0;
  endtask

  task automatic run_case(input int base, input int len, input bit lp, input int pct,
                          input int beats, input bit restart, input bit both);
    int  got, first_t, last_t, done_t, done_n, t_nb, n_exp;
    bit  stopped, rdy, sp, st;
    logic [DW:0] e;
    exp_q.delete();
    n_exp = lp ? beats + 2 : len;
    for (int i = 0; i < n_exp; i++) begin
      int idx;
      idx = i % len;
      exp_q.push_back({(idx == len - 1), mem_model[(base + idx) % DEPTH]});
    end
    got = 0; first_t = -1; last_t = -1; done_t = -1; done_n = 0; t_nb = -1; stopped = 0;
    base_addr = AW'(base);
    length    = (AW + 1)'(len);
    loop      = lp;
    tick(1'b1, 1'b1, both);
    for (int c = 1; c < 5000 && done_n == 0; c++) begin
      rdy = (pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < pct);
      sp  = lp && (got >= beats) && !stopped;
      st  = restart && (c == 3);
      if (st) begin
        base_addr = AW'(base + 7);
        length    = (AW + 1)'(len + 1);
        loop      = ~lp;
      end
      tick(rdy, st, sp);
      if (sp) stopped = 1;
      if (c == 1) begin
        check("busy_after_start", {63'd0, s_busy}, 64'd1);
`ifdef MEMORY_STREAM_SOURCE_STATS_EN
        check("beat_count_cleared", {32'd0, beat_count}, 64'd0);
`endif
      end
      if (s_valid && first_t < 0) first_t = c;
      if (s_beat) begin
        if (exp_q.size() == 0) begin
          check("beat_overflow", 64'(got + 1), 64'(n_exp));
        end else begin
          e = exp_q.pop_front();
          check("beat", {31'd0, s_last, s_data}, {31'd0, e});
        end
        got++;
        last_t = c;
        if (got == beats) t_nb = c;
      end
      if (s_done) begin
        done_n++;
        done_t = c;
        check("busy_low_with_done", {63'd0, s_busy}, 64'd0);
      end
    end
    check("done_once", 64'(done_n), 64'd1);
    check("first_valid_latency", 64'(first_t), 64'd3);
    if (!lp) begin
      check("beat_total", 64'(got), 64'(len));
      check("done_after_last_beat", 64'(done_t), 64'(last_t + 1));
      if (pct >= 100) check("no_bubbles", 64'(last_t - first_t), 64'(len - 1));
    end else begin
      check("loop_tail_ok", 64'((got >= beats) && (got <= beats + 2)), 64'd1);
      if (pct >= 100) check("loop_no_bubbles", 64'(t_nb - first_t), 64'(beats - 1));
    end
`ifdef MEMORY_STREAM_SOURCE_STATS_EN
    check("beat_count_final", {32'd0, beat_count}, 64'(got));
`endif
    tick(1'b1, 1'b0, 1'b0);
    check("done_pulse_ends", {62'd0, s_done, s_busy}, 64'd0);
  endtask

  initial begin
    cases[0] = '{base: 0,    len: 4,    lp: 0, pct: 100, beats: 4,    restart: 0, both: 0};
    cases[1] = '{base: 1022, len: 4,    lp: 0, pct: 100, beats: 4,    restart: 0, both: 0};
    cases[2] = '{base: 0,    len: 3,    lp: 1, pct: 100, beats: 9,    restart: 0, both: 0};
    cases[3] = '{base: 0,    len: 1024, lp: 0, pct: 50,  beats: 1024, restart: 0, both: 0};
    cases[4] = '{base: 100,  len: 1,    lp: 0, pct: 100, beats: 1,    restart: 0, both: 1};
    cases[5] = '{base: 1023, len: 1,    lp: 1, pct: 100, beats: 5,    restart: 0, both: 0};
    cases[6] = '{base: 10,   len: 7,    lp: 0, pct: 30,  beats: 7,    restart: 1, both: 0};
    cases[7] = '{base: 500,  len: 2,    lp: 1, pct: 60,  beats: 11,   restart: 0, both: 0};

    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; stop = 1'b0; loop = 1'b0; base_addr = '0; length = '0; ready = 1'b0;
    repeat (3) @(negedge clk_hifreq);
    #1;
    check("reset_outputs", {28'd0, valid, last, busy, done, data_out}, 64'd0);
    rst_n = 1'b1;

    for (int k = 0; k < DEPTH; k++) ram_write(k, 32'h1000_0000 + DW'(k));
    ram_write_end();

    foreach (cases[i])
      run_case(cases[i].base, cases[i].len, cases[i].lp, cases[i].pct,
               cases[i].beats, cases[i].restart, cases[i].both);

    // zero-length start is ignored
    base_addr = 10'd5; length = '0; loop = 1'b0;
    tick(1'b1, 1'b1, 1'b0);
    for (int c = 0; c < 4; c++) begin
      tick(1'b1, 1'b0, 1'b0);
      check("zero_len_idle", {62'd0, s_busy, s_done}, 64'd0);
    end

    // reset while RUN with valid held high
    base_addr = '0; length = 11'd100; loop = 1'b0;
    tick(1'b0, 1'b1, 1'b0);
    for (int c = 0; c < 10 && !s_valid; c++) tick(1'b0, 1'b0, 1'b0);
    check("valid_before_reset", {63'd0, s_valid}, 64'd1);
    @(negedge clk_hifreq);
    rst_n = 1'b0;
    #1;
    check("async_reset_clears", {60'd0, valid, last, busy, done}, 64'd0);
    prev_valid = 1'b0;
    repeat (2) @(negedge clk_hifreq);
    rst_n = 1'b1;
    run_case(5, 6, 0, 100, 6, 0, 0);

    // random contents and random windows
    for (int k = 0; k < DEPTH; k++) ram_write(k, DW'($urandom));
    ram_write_end();
    for (int r = 0; r < 4; r++) begin
      int b, l, p;
      bit lp;
      b  = $urandom_range(0, DEPTH - 1);
      l  = $urandom_range(1, 40);
      lp = 1'($urandom_range(0, 1));
      p  = $urandom_range(20, 100);
      run_case(b, l, lp, p, lp ? 2 * l + 1 : l, 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/memory_stream_source.md
# memory_stream_source

Parametrised streaming memory source for the high-frequency test environment. Holds a loadable block of sample words in an on-chip synchronous RAM and replays a programmable window (base address, length) onto a valid/ready stream, one word per cycle at full throughput, in one-shot or loop mode. Downstream backpressure is absorbed by a 2-entry output buffer covering the RAM read latency, so no word is lost or duplicated.

## Interface
Parameters:
- DATA_W, 32, stream/RAM word width
- ADDR_W, 10, RAM address width; depth = 2**ADDR_W

Ports:
- clk_hifreq  in  1  sole clock, all logic rising-edge
- rst_n  in  1  asynchronous, active-low reset
- wr_en  in  1  RAM load strobe
- wr_addr  in  ADDR_W  load address
- wr_data  in  DATA_W  load data
- start  in  1  begin replay (pulse); ignored while busy
- stop  in  1  abort replay (pulse); ignored while idle
- loop  in  1  sampled at start: 1 = repeat window, 0 = one pass
- base_addr  in  ADDR_W  window start, sampled at start
- length  in  ADDR_W+1  window word count, sampled at start; 1..2**ADDR_W
- ready  in  1  downstream accepts word
- valid  out  1  data_out holds a word
- data_out  out  DATA_W  stream word
- last  out  1  qualifies final word of each pass
- busy  out  1  replay in progress (RUN or DRAIN)
- done  out  1  one-cycle pulse when replay fully completes

## Operation
- FSM states IDLE, RUN, DRAIN.
- IDLE: start with length != 0 -> RUN; captures base_addr, length, loop; read offset = 0. start with length == 0 -> stays IDLE, no done.
- RUN: issues a RAM read when buffer occupancy + reads in flight < 2. Address = (base + offset) mod 2**ADDR_W (window wraps past top of RAM). Offset increments per issued read; at offset == length-1 the read is tagged last; then offset -> 0 if loop, else RUN -> DRAIN.
- stop in RUN: no further reads issued, -> DRAIN; already issued words are still delivered. A delivered word carries last only if it was tagged.
- DRAIN: when buffer empty and nothing in flight -> IDLE, done pulses that cycle.
- start and stop in the same cycle while IDLE: start wins. stop in DRAIN: no effect.
- Beat transfers when valid && ready. valid never drops without a transfer; data_out/last stable while valid && !ready.
- Writes are accepted in any state; a read and write to the same address in one cycle returns the old data.
- Reset mid-operation: FSM -> IDLE, buffer and in-flight tracking cleared; RAM contents undefined-but-retained (not cleared).

## Timing
- Reset values: valid 0, last 0, busy 0, done 0, data_out 0.
- RAM read latency 1 cycle (address registered, q next cycle).
- start sampled at edge N -> busy high after edge N; first valid high after edge N+2.
- ready held high: one word per cycle, no bubbles, including across loop wrap.
- One-shot, length L, ready high: last on word L; done pulses the cycle after the last beat transfers; busy falls with done.
- ready low: at most 2 words held; reads resume the cycle after a buffer slot frees.

## Configuration
- MEMORY_STREAM_SOURCE_STATS_EN defined: adds output beat_count (32 bits), counts transferred beats since start, cleared at start and reset, saturates at 2**32-1, holds after done.
- Undefined: port and counter absent; all other behaviour identical.

## Structure
- Package memory_stream_source_pkg: state enum (IDLE/RUN/DRAIN), buffer-depth constant (2), buffer entry struct {data, last}.
- Sub-module source_ram: simple dual-port (one write, one read) synchronous RAM, DATA_W x 2**ADDR_W, 1-cycle registered read, read-old-on-collision.
- Output buffer, address generation and FSM stay in the top module.

## Test plan
- Load addr k with 0x1000_0000+k (k=0..1023); start base=0, length=4, loop=0, ready=1 -> data 0x1000_0000..0x1000_0003, last on 4th, first valid 2 cycles after start, done 1 cycle after last beat.
- base=1022, length=4 -> words from addresses 1022, 1023, 0, 1 in order.
- loop=1, length=3, ready=1 for 9 beats -> sequence repeats 3 times, last on beats 3, 6, 9, no gaps; stop -> in-flight words delivered, then done, busy 0.
- Random ready (50%) over length=1024 one-shot -> exactly 1024 beats, in order, no duplicates, data stable under stall.
- Assert rst_n low mid-RUN with valid high -> valid, busy, done 0 immediately; after release, a new start replays correctly from its base.
- With MEMORY_STREAM_SOURCE_STATS_EN: length=5 one-shot -> beat_count reads 5 after done; new start clears it to 0.
